// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared definitions for the alu_arbiter slice.
//   - arb_state_t : FSM state encoding (IDLE / EXEC / RESP)
//   - instruction field offsets and widths (32-bit instruction layout)
//   - PTR_RST     : reset value of the round-robin last-grant pointer
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Instruction field layout (bit positions within a 32-bit word)
    localparam int OPCODE_LSB = 26;
    localparam int OPCODE_W   = 6;
    localparam int SHAMT_LSB  = 6;
    localparam int SHAMT_W    = 5;
    localparam int FUNC_LSB   = 0;
    localparam int FUNC_W     = 6;
    localparam int RAW_LSB    = 0;
    localparam int RAW_W      = 16;

    // Pointer starts at 1 so requester 0 wins the first tie.
    localparam logic PTR_RST = 1'b1;

endpackage

// File: rtl/alu_arb_pick.sv
// alu_arb_pick: combinational grant selector for two requesters.
// Ports:
//   valid0, valid1 : request pending from requester 0 / 1
//   last_ptr       : index of the requester granted most recently
//   grant          : one-hot grant vector (bit 0 = requester 0)
//   grant_id       : index of the granted requester (0 when nothing granted)
// Configuration macro: ALU_ARB_FIXED_PRIO_EN
//   defined     -> fixed priority, requester 0 always wins, last_ptr ignored
//   not defined -> round-robin, on a tie the requester other than last_ptr wins
module alu_arb_pick (
    input  logic       valid0,
    input  logic       valid1,
    input  logic       last_ptr,
    output logic [1:0] grant,
    output logic       grant_id
);

`ifdef ALU_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = last_ptr;

    always_comb begin
        grant    = 2'b00;
        grant_id = 1'b0;
        if (valid0) begin
            grant = 2'b01;
        end else if (valid1) begin
            grant    = 2'b10;
            grant_id = 1'b1;
        end
    end
`else
    always_comb begin
        grant    = 2'b00;
        grant_id = 1'b0;
        if (valid0 && valid1) begin
            // Tie: serve whoever was not served last.
            grant_id = ~last_ptr;
            grant    = last_ptr ? 2'b01 : 2'b10;
        end else if (valid0) begin
            grant = 2'b01;
        end else if (valid1) begin
            grant    = 2'b10;
            grant_id = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two instruction requesters.
//
// Handshake: a request transfers on a cycle where REQx_VALID && REQx_READY;
// READY is only raised in IDLE, for the granted requester, and never while
// RST is high. A response transfers on a cycle where RSP_VALID && RSP_READY;
// RSP_* stay constant while RSP_VALID is high and RSP_READY is low.
//
// Ports:
//   CLK, RST                  : clock (rising edge), async active-high reset
//   REQx_VALID/READY          : request handshake, x = 0/1
//   REQx_INSTR/RS/RT          : instruction word and operands
//   RSP_VALID/READY           : response handshake
//   RSP_ID/RESULT/SIG_B       : requester index and captured ALU outputs
//   ALU_OPCODE/RS_VAL/RT_VAL/SHAMT/FUNC/RAW_VAL : registered ALU drive
//   ALU_RESULT/SIG_B          : combinational ALU outputs
//   DBG_STATE                 : current FSM state
// Configuration macro: ALU_ARB_FIXED_PRIO_EN (selects fixed priority in
// alu_arb_pick; default is round-robin).
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int INSTR_W = 32
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               REQ0_VALID,
    output logic               REQ0_READY,
    input  logic [INSTR_W-1:0] REQ0_INSTR,
    input  logic [DATA_W-1:0]  REQ0_RS,
    input  logic [DATA_W-1:0]  REQ0_RT,
    input  logic               REQ1_VALID,
    output logic               REQ1_READY,
    input  logic [INSTR_W-1:0] REQ1_INSTR,
    input  logic [DATA_W-1:0]  REQ1_RS,
    input  logic [DATA_W-1:0]  REQ1_RT,
    output logic               RSP_VALID,
    input  logic               RSP_READY,
    output logic               RSP_ID,
    output logic [DATA_W-1:0]  RSP_RESULT,
    output logic               RSP_SIG_B,
    output logic [5:0]         ALU_OPCODE,
    output logic [DATA_W-1:0]  ALU_RS_VAL,
    output logic [DATA_W-1:0]  ALU_RT_VAL,
    output logic [4:0]         ALU_SHAMT,
    output logic [5:0]         ALU_FUNC,
    output logic [15:0]        ALU_RAW_VAL,
    input  logic [DATA_W-1:0]  ALU_RESULT,
    input  logic               ALU_SIG_B,
    output logic [1:0]         DBG_STATE
);

    arb_state_t         state;
    arb_state_t         state_nxt;
    logic               last_ptr;
    logic [1:0]         grant;
    logic               grant_id;
    logic               accept;
    logic [INSTR_W-1:0] sel_instr;
    logic [DATA_W-1:0]  sel_rs;
    logic [DATA_W-1:0]  sel_rt;
    logic               unused_instr;

    alu_arb_pick u_pick (
        .valid0   (REQ0_VALID),
        .valid1   (REQ1_VALID),
        .last_ptr (last_ptr),
        .grant    (grant),
        .grant_id (grant_id)
    );

    // RST gating keeps READY at its reset value while reset is held.
    assign accept     = (state == IDLE) && !RST && (REQ0_VALID || REQ1_VALID);
    assign REQ0_READY = accept && grant[0];
    assign REQ1_READY = accept && grant[1];
    assign RSP_VALID  = (state == RESP);
    assign DBG_STATE  = state;

    assign sel_instr = grant_id ? REQ1_INSTR : REQ0_INSTR;
    assign sel_rs    = grant_id ? REQ1_RS    : REQ0_RS;
    assign sel_rt    = grant_id ? REQ1_RT    : REQ0_RT;

    // Bits between RAW and OPCODE (and any above bit 31) are not decoded.
    assign unused_instr = ^sel_instr;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (RSP_READY) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ALU drive registers are loaded only on acceptance and otherwise keep
    // the last operation; RSP_RESULT/SIG_B sample the ALU at the end of EXEC.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ALU_OPCODE  <= '0;
            ALU_RS_VAL  <= '0;
            ALU_RT_VAL  <= '0;
            ALU_SHAMT   <= '0;
            ALU_FUNC    <= '0;
            ALU_RAW_VAL <= '0;
            RSP_ID      <= 1'b0;
            RSP_RESULT  <= '0;
            RSP_SIG_B   <= 1'b0;
            last_ptr    <= PTR_RST;
        end else begin
            if (accept) begin
                ALU_OPCODE  <= sel_instr[OPCODE_LSB +: OPCODE_W];
                ALU_SHAMT   <= sel_instr[SHAMT_LSB +: SHAMT_W];
                ALU_FUNC    <= sel_instr[FUNC_LSB +: FUNC_W];
                ALU_RAW_VAL <= sel_instr[RAW_LSB +: RAW_W];
                ALU_RS_VAL  <= sel_rs;
                ALU_RT_VAL  <= sel_rt;
                RSP_ID      <= grant_id;
                last_ptr    <= grant_id;
            end
            if (state == EXEC) begin
                RSP_RESULT <= ALU_RESULT;
                RSP_SIG_B  <= ALU_SIG_B;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed + randomized bench for alu_arbiter with a small
// behavioural ALU attached to the ALU_* ports.
module tb_alu_arbiter;
    localparam int DATA_W  = 32;
    localparam int INSTR_W = 32;
    localparam int EXP_W   = DATA_W + 2;   // {id, sig_b, result}

    logic               CLK = 1'b0;
    logic               RST;
    logic               REQ0_VALID, REQ0_READY, REQ1_VALID, REQ1_READY;
    logic [INSTR_W-1:0] REQ0_INSTR, REQ1_INSTR;
    logic [DATA_W-1:0]  REQ0_RS, REQ0_RT, REQ1_RS, REQ1_RT;
    logic               RSP_VALID, RSP_READY, RSP_ID, RSP_SIG_B;
    logic [DATA_W-1:0]  RSP_RESULT;
    logic [5:0]         ALU_OPCODE, ALU_FUNC;
    logic [DATA_W-1:0]  ALU_RS_VAL, ALU_RT_VAL, ALU_RESULT;
    logic [4:0]         ALU_SHAMT;
    logic [15:0]        ALU_RAW_VAL;
    logic               ALU_SIG_B;
    logic [1:0]         DBG_STATE;

    alu_arbiter #(.DATA_W(DATA_W), .INSTR_W(INSTR_W)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_INSTR(REQ0_INSTR),
        .REQ0_RS(REQ0_RS), .REQ0_RT(REQ0_RT),
        .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_INSTR(REQ1_INSTR),
        .REQ1_RS(REQ1_RS), .REQ1_RT(REQ1_RT),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_ID(RSP_ID),
        .RSP_RESULT(RSP_RESULT), .RSP_SIG_B(RSP_SIG_B),
        .ALU_OPCODE(ALU_OPCODE), .ALU_RS_VAL(ALU_RS_VAL), .ALU_RT_VAL(ALU_RT_VAL),
        .ALU_SHAMT(ALU_SHAMT), .ALU_FUNC(ALU_FUNC), .ALU_RAW_VAL(ALU_RAW_VAL),
        .ALU_RESULT(ALU_RESULT), .ALU_SIG_B(ALU_SIG_B), .DBG_STATE(DBG_STATE)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural ALU ----------------
    // Returns {zero_flag, result}.
    function automatic logic [DATA_W:0] alu_calc(input logic [5:0] op, input logic [4:0] sh,
                                                input logic [5:0] fn, input logic [15:0] raw,
                                                input logic [31:0] rs, input logic [31:0] rt);
        logic [31:0] r;
        if (op == 6'h00) begin
            case (fn)
                6'h00:   r = rt << sh;
                6'h02:   r = rt >> sh;
                6'h20:   r = rs + rt;
                6'h22:   r = rs - rt;
                6'h24:   r = rs & rt;
                6'h25:   r = rs | rt;
                default: r = rs ^ rt;
            endcase
        end else if (op == 6'h08) begin
            r = rs + {{16{raw[15]}}, raw};
        end else begin
            r = rs ^ {16'h0, raw};
        end
        return {(r == 32'h0), r};
    endfunction

    always_comb {ALU_SIG_B, ALU_RESULT} = alu_calc(ALU_OPCODE, ALU_SHAMT, ALU_FUNC,
                                                   ALU_RAW_VAL, ALU_RS_VAL, ALU_RT_VAL);

    // Reference result straight from the instruction word.
    function automatic logic [DATA_W:0] ref_calc(input logic [95:0] op);
        logic [31:0] ins;
        ins = op[95:64];
        return alu_calc(ins[31:26], ins[10:6], ins[5:0], ins[15:0], op[63:32], op[31:0]);
    endfunction

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;

    logic [95:0]      rq0[$];          // pending {instr, rs, rt} per requester
    logic [95:0]      rq1[$];
    logic [EXP_W-1:0] exp_q[$];        // expected responses in order
    int               glog[$];         // observed grant order
    bit               rsp_rand = 0;
    int               obs_acc = 0;
    int               obs_rsp = 0;

    // Reference model: an operation is "in flight" from its acceptance until
    // its response is consumed; the response is visible from the second cycle
    // after acceptance onward.
    bit          inflight = 0;
    int          age = 0;
    bit          m_last = 1;
    bit          m_op_valid = 0;
    logic [95:0] m_op = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        inflight   = 0;
        age        = 0;
        m_last     = 1;
        m_op_valid = 0;
        m_op       = '0;
        exp_q.delete();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_req0_ready"}, 64'(REQ0_READY), 64'(0));
        chk({tag, "_req1_ready"}, 64'(REQ1_READY), 64'(0));
        chk({tag, "_rsp_valid"},  64'(RSP_VALID),  64'(0));
        chk({tag, "_rsp_id"},     64'(RSP_ID),     64'(0));
        chk({tag, "_rsp_result"}, 64'(RSP_RESULT), 64'(0));
        chk({tag, "_rsp_sig_b"},  64'(RSP_SIG_B),  64'(0));
        chk({tag, "_alu_fields"},
            64'({ALU_OPCODE, ALU_SHAMT, ALU_FUNC, ALU_RAW_VAL}), 64'(0));
        chk({tag, "_alu_ops"}, {ALU_RS_VAL, ALU_RT_VAL}, 64'(0));
    endtask

    // ---------------- driver tasks ----------------
    task automatic present();
        if (rq0.size() > 0) begin
            REQ0_VALID = 1'b1;
            {REQ0_INSTR, REQ0_RS, REQ0_RT} = rq0[0];
        end else begin
            REQ0_VALID = 1'b0;
        end
        if (rq1.size() > 0) begin
            REQ1_VALID = 1'b1;
            {REQ1_INSTR, REQ1_RS, REQ1_RT} = rq1[0];
        end else begin
            REQ1_VALID = 1'b0;
        end
        if (rsp_rand) RSP_READY = 1'($urandom_range(0, 1));
    endtask

    function automatic logic [95:0] mk_op(input logic [31:0] ins, input logic [31:0] rs,
                                          input logic [31:0] rt);
        return {ins, rs, rt};
    endfunction

    function automatic logic [95:0] rand_op();
        logic [31:0] ins, rs, rt;
        int k;
        ins = $urandom;
        rs  = $urandom;
        rt  = $urandom;
        k   = $urandom_range(0, 7);
        case (k)
            0: begin ins[31:26] = 6'h00; ins[5:0] = 6'h00; end
            1: begin ins[31:26] = 6'h00; ins[5:0] = 6'h02; end
            2: begin ins[31:26] = 6'h00; ins[5:0] = 6'h20; end
            3: begin
                ins[31:26] = 6'h00; ins[5:0] = 6'h22;
                if ($urandom_range(0, 1) == 1) rt = rs;
            end
            4: begin ins[31:26] = 6'h00; ins[5:0] = 6'h24; end
            5: begin ins[31:26] = 6'h00; ins[5:0] = 6'h25; end
            6: ins[31:26] = 6'h08;
            default: ;
        endcase
        return {ins, rs, rt};
    endfunction

    // One clock cycle: check at the falling edge, advance the model across
    // the rising edge, then present the next inputs 1 time unit later.
    task automatic tick();
        logic             g0, g1, ev, hs;
        logic [EXP_W-1:0] e;
        logic [31:0]      ins, ers, ert;
        logic [95:0]      op;
        @(negedge CLK);
        g0 = 1'b0;
        g1 = 1'b0;
        if (!inflight) begin
            if (REQ0_VALID && REQ1_VALID) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
                g0 = 1'b1;
`else
                if (m_last) g0 = 1'b1; else g1 = 1'b1;
`endif
            end else begin
                g0 = REQ0_VALID;
                g1 = REQ1_VALID;
            end
        end
        chk("req0_ready", 64'(REQ0_READY), 64'(g0));
        chk("req1_ready", 64'(REQ1_READY), 64'(g1));
        if (REQ0_READY) begin obs_acc++; glog.push_back(0); end
        if (REQ1_READY) glog.push_back(1);
        if (RSP_VALID) obs_rsp++;
        ev = inflight && (age >= 1);
        chk("rsp_valid", 64'(RSP_VALID), 64'(ev));
        if (ev) begin
            if (exp_q.size() > 0) begin
                e = exp_q[0];
                chk("rsp_id",     64'(RSP_ID),     64'(e[EXP_W-1]));
                chk("rsp_sig_b",  64'(RSP_SIG_B),  64'(e[DATA_W]));
                chk("rsp_result", 64'(RSP_RESULT), 64'(e[DATA_W-1:0]));
            end else begin
                chk("exp_q_nonempty", 64'(0), 64'(1));
            end
        end
        if (m_op_valid) begin
            ins = m_op[95:64]; ers = m_op[63:32]; ert = m_op[31:0];
        end else begin
            ins = '0; ers = '0; ert = '0;
        end
        chk("alu_opcode", 64'(ALU_OPCODE),  64'(ins[31:26]));
        chk("alu_shamt",  64'(ALU_SHAMT),   64'(ins[10:6]));
        chk("alu_func",   64'(ALU_FUNC),    64'(ins[5:0]));
        chk("alu_raw",    64'(ALU_RAW_VAL), 64'(ins[15:0]));
        chk("alu_rs",     64'(ALU_RS_VAL),  64'(ers));
        chk("alu_rt",     64'(ALU_RT_VAL),  64'(ert));
        hs = ev && RSP_READY;
        @(posedge CLK);
        if (g0 || g1) begin
            op = g1 ? rq1.pop_front() : rq0.pop_front();
            inflight   = 1;
            age        = 0;
            m_last     = g1;
            m_op       = op;
            m_op_valid = 1;
            exp_q.push_back({g1, ref_calc(op)});
        end else if (inflight) begin
            if (hs) begin
                inflight = 0;
                void'(exp_q.pop_front());
            end else begin
                age++;
            end
        end
        #1;
        present();
    endtask

    task automatic do_reset();
        RST = 1'b1;
        #1;
        model_clear();
        chk_zero("reset");
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        present();
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while ((rq0.size() > 0 || rq1.size() > 0 || inflight) && n < bound) begin
            tick();
            n++;
        end
        chk("drain_done", 64'(rq0.size() + rq1.size() + int'(inflight)), 64'(0));
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int exp_g[4];
        REQ0_VALID = 0; REQ1_VALID = 0; RSP_READY = 0;
        REQ0_INSTR = '0; REQ0_RS = '0; REQ0_RT = '0;
        REQ1_INSTR = '0; REQ1_RS = '0; REQ1_RT = '0;
        do_reset();

        // Single REQ0: SLL by 1 of 12
        RSP_READY = 1'b1;
        rq0.push_back(mk_op(32'h0000_0040, 32'd0, 32'd12));
        present();
        tick();
        tick();
        chk("t1_rsp_valid", 64'(RSP_VALID), 64'(1));
        chk("t1_rsp_id", 64'(RSP_ID), 64'(0));
        chk("t1_rsp_result", 64'(RSP_RESULT), 64'(24));
        tick();
        tick();

        // Tie from reset with RSP_READY held high
        do_reset();
        RSP_READY = 1'b1;
        glog.delete();
        for (int i = 0; i < 4; i++) begin
            rq0.push_back(rand_op());
            rq1.push_back(rand_op());
        end
        present();
        drain(100);
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_g = '{0, 0, 0, 0};
`else
        exp_g = '{0, 1, 0, 1};
`endif
        chk("tie_grants", 64'(glog.size()), 64'(8));
        for (int i = 0; i < 4; i++) begin
            if (glog.size() > i) chk("tie_order", 64'(glog[i]), 64'(exp_g[i]));
        end

        // Response stall for 5 cycles with a competing request waiting
        RSP_READY = 1'b0;
        rq0.push_back(mk_op(32'h0000_0020, 32'd7, 32'd9));   // ADD -> 16
        present();
        tick();
        tick();
        rq1.push_back(mk_op(32'h0000_0040, 32'd0, 32'd3));
        present();
        repeat (5) tick();
        chk("stall_result", 64'(RSP_RESULT), 64'(16));
        chk("stall_no_accept", 64'(rq1.size()), 64'(1));
        RSP_READY = 1'b1;
        tick();
        tick();
        chk("after_stall_accept", 64'(rq1.size()), 64'(0));
        drain(20);

        // REQ1 alone: SLL by 1 of 35
        rq1.push_back(mk_op(32'h0000_0040, 32'd0, 32'd35));
        present();
        tick();
        chk("t5_exec_shamt", 64'(ALU_SHAMT), 64'(1));
        tick();
        chk("t5_rsp_id", 64'(RSP_ID), 64'(1));
        chk("t5_rsp_result", 64'(RSP_RESULT), 64'(70));
        tick();

        // Reset during EXEC
        rq0.push_back(mk_op(32'h0000_0025, 32'h0f0f, 32'hf0f0));
        present();
        tick();
        #3;
        RST = 1'b1;
        #1;
        chk_zero("rst_exec");
        model_clear();
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        present();
        repeat (3) tick();
        rq0.push_back(mk_op(32'h0000_0025, 32'h0f0f, 32'hf0f0));
        present();
        tick();
        tick();
        chk("rst_reissue_valid", 64'(RSP_VALID), 64'(1));
        chk("rst_reissue_result", 64'(RSP_RESULT), 64'(32'hffff));
        tick();

        // Throughput: continuous REQ0 with RSP_READY tied high
        RSP_READY = 1'b1;
        for (int i = 0; i < 12; i++) rq0.push_back(rand_op());
        present();
        obs_acc = 0;
        obs_rsp = 0;
        repeat (30) tick();
        chk("thru_accepts", 64'(obs_acc), 64'(10));
        chk("thru_rsp_cycles", 64'(obs_rsp), 64'(10));
        drain(20);

        // Randomized traffic on both requesters with random RSP_READY
        rsp_rand = 1;
        for (int i = 0; i < 25; i++) begin
            rq0.push_back(rand_op());
            rq1.push_back(rand_op());
        end
        present();
        drain(3000);
        rsp_rand = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
